overload_responder: RTL and testbench

Emergency-side consumer of the weight controller's overload flag. When `weight_limit_exceeded` rises, the block blocks car motion, holds the doors open once the car is stopped, and drives an alarm buzzer and lamp. It waits for a configured number of passenger-exit pulses, then pulses `reset_weight_flip` back to the weight controller and confirms the flag has cleared before re-arming. It sits between the weight controller and the motion/door controllers in the emergency subsystem.

---
 rtl/elevator_emergency_pkg.sv | 21 ++
 rtl/beep_timer.sv | 32 +++
 rtl/overload_responder.sv | 140 ++++++++++++++
 tb/tb_overload_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/elevator_emergency_pkg.sv
// Shared types and defaults for the elevator emergency subsystem.
package elevator_emergency_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ALARM     = 3'd1,
    ST_WAIT_EXIT = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_SETTLE    = 3'd4
  } overload_state_t;

  localparam int unsigned EXIT_COUNT_DEF    = 1;
  localparam int unsigned BEEP_HALF_DEF     = 8;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  // States in which the alarm buzzer is sounding.
  function automatic logic is_beep_state(input overload_state_t s);
    return (s == ST_ALARM) || (s == ST_WAIT_EXIT);
  endfunction

endpackage

// File: rtl/beep_timer.sv
// Square-wave generator for the overload buzzer: tone flips every BEEP_HALF
// enabled cycles and restarts low whenever enable drops.
module beep_timer
  import elevator_emergency_pkg::*;
#(
  parameter int unsigned BEEP_HALF = BEEP_HALF_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tone
);

  localparam int unsigned CW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [CW-1:0] HALF_TC = CW'(BEEP_HALF - 1);

  logic [CW-1:0] count;

  // Half-period counter; tone toggles at the terminal count.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      count <= '0;
      tone  <= 1'b0;
    end else if (count == HALF_TC) begin
      count <= '0;
      tone  <= ~tone;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/overload_responder.sv
// Overload responder: reacts to the weight controller's overload flag by
// inhibiting motion, holding the doors once stopped, and sounding the alarm
// until enough passengers have left, then clears the flag and re-arms.
// Build option: define OVERLOAD_BUZZER_EN to instantiate the beep timer;
// otherwise buzzer is tied low.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | no overload, all outputs low
// ST_ALARM     | overload seen, car may still be moving, lamp + buzzer
// ST_WAIT_EXIT | car stopped, doors held, counting passenger exits
// ST_CLEAR     | one-cycle reset_weight_flip pulse to weight controller
// ST_SETTLE    | waiting for the flag to drop; timeout means re-overload
module overload_responder
  import elevator_emergency_pkg::*;
#(
  parameter int unsigned EXIT_COUNT    = EXIT_COUNT_DEF,
  parameter int unsigned BEEP_HALF     = BEEP_HALF_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic weight_limit_exceeded,
  input  logic elevator_moving,
  input  logic passenger_exit,
  output logic reset_weight_flip,
  output logic motion_inhibit,
  output logic door_hold,
  output logic overload_led,
  output logic buzzer
);

  localparam int unsigned EW = $clog2(EXIT_COUNT + 1);
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [EW-1:0] EXIT_TARGET = EW'(EXIT_COUNT);
  localparam logic [EW-1:0] EXIT_LAST   = EW'(EXIT_COUNT - 1);
  localparam logic [SW-1:0] SETTLE_TC   = SW'(SETTLE_CYCLES - 1);

  if (EXIT_COUNT < 1 || EXIT_COUNT > 15) begin : g_bad_exit_count
    $error("overload_responder: EXIT_COUNT must be 1..15");
  end
  if (BEEP_HALF < 1) begin : g_bad_beep_half
    $error("overload_responder: BEEP_HALF must be at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("overload_responder: SETTLE_CYCLES must be at least 1");
  end

  overload_state_t state, state_next;
  logic [EW-1:0]   exit_count, exit_next;
  logic [SW-1:0]   settle_count, settle_next;

  // Next-state and counter update rules.
  always_comb begin
    state_next  = state;
    exit_next   = exit_count;
    settle_next = settle_count;
    case (state)
      ST_IDLE: begin
        if (weight_limit_exceeded) state_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (!elevator_moving) begin
          state_next = ST_WAIT_EXIT;
          exit_next  = '0;
        end
      end
      ST_WAIT_EXIT: begin
        if (passenger_exit) begin
          if (exit_count == EXIT_TARGET) begin
            exit_next = EXIT_TARGET;
          end else begin
            exit_next = exit_count + 1'b1;
          end
          // The pulse that completes the count moves us on in the same edge.
          if (exit_count >= EXIT_LAST) state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_next  = ST_SETTLE;
        settle_next = '0;
      end
      ST_SETTLE: begin
        if (!weight_limit_exceeded) begin
          state_next = ST_IDLE;
        end else if (settle_count == SETTLE_TC) begin
          // Flag refused to drop: load is still too high, go back to waiting.
          state_next = ST_WAIT_EXIT;
          exit_next  = '0;
        end else begin
          settle_next = settle_count + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and outputs registered together, outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      exit_count        <= '0;
      settle_count      <= '0;
      reset_weight_flip <= 1'b0;
      motion_inhibit    <= 1'b0;
      door_hold         <= 1'b0;
      overload_led      <= 1'b0;
    end else begin
      state             <= state_next;
      exit_count        <= exit_next;
      settle_count      <= settle_next;
      reset_weight_flip <= (state_next == ST_CLEAR);
      motion_inhibit    <= (state_next != ST_IDLE);
      door_hold         <= (state_next == ST_WAIT_EXIT) || (state_next == ST_CLEAR) ||
                           (state_next == ST_SETTLE);
      overload_led      <= is_beep_state(state_next);
    end
  end

`ifdef OVERLOAD_BUZZER_EN
  // Timer runs only while staying inside an alarm episode, so the tone starts
  // low on entry and is already low on the first cycle after leaving.
  logic beep_enable;
  assign beep_enable = is_beep_state(state) && is_beep_state(state_next);

  beep_timer #(
    .BEEP_HALF(BEEP_HALF)
  ) u_beep_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (beep_enable),
    .tone   (buzzer)
  );
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_overload_responder.sv
// Testbench for overload_responder: directed test-plan sequences followed by
// randomized traffic, checked per cycle against a behavioural model through
// an expected-output queue.
module tb_overload_responder;

  localparam int EC = 2;
  localparam int BH = 8;
  localparam int SC = 4;

  localparam int P_IDLE   = 0;
  localparam int P_ALARM  = 1;
  localparam int P_WAIT   = 2;
  localparam int P_CLEAR  = 3;
  localparam int P_SETTLE = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic weight_limit_exceeded;
  logic elevator_moving;
  logic passenger_exit;
  logic reset_weight_flip;
  logic motion_inhibit;
  logic door_hold;
  logic overload_led;
  logic buzzer;

  always #5 clk = ~clk;

  overload_responder #(
    .EXIT_COUNT   (EC),
    .BEEP_HALF    (BH),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .weight_limit_exceeded(weight_limit_exceeded),
    .elevator_moving      (elevator_moving),
    .passenger_exit       (passenger_exit),
    .reset_weight_flip    (reset_weight_flip),
    .motion_inhibit       (motion_inhibit),
    .door_hold            (door_hold),
    .overload_led         (overload_led),
    .buzzer               (buzzer)
  );

  typedef struct packed {
    logic flip;
    logic inhibit;
    logic door;
    logic led;
    logic buzz;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: where the sequence is, how many exits counted, how long
  // the flag has lingered after the clear, and how long the alarm has sounded.
  int ph = P_IDLE;
  int exits = 0;
  int settle = 0;
  int age = 0;

  task automatic apply(input logic r, input logic f, input logic m, input logic e);
    int prev;
    bit beeping;
    exp_t x;
    reset_n = r;
    weight_limit_exceeded = f;
    elevator_moving = m;
    passenger_exit = e;
    prev = ph;
    if (!r) begin
      ph = P_IDLE;
      exits = 0;
      settle = 0;
      age = 0;
    end else begin
      case (ph)
        P_IDLE:  if (f) ph = P_ALARM;
        P_ALARM: if (!m) begin ph = P_WAIT; exits = 0; end
        P_WAIT:  if (e) begin
          exits = exits + 1;
          if (exits >= EC) ph = P_CLEAR;
        end
        P_CLEAR: begin ph = P_SETTLE; settle = 0; end
        default: begin
          if (!f) ph = P_IDLE;
          else begin
            settle = settle + 1;
            if (settle >= SC) begin ph = P_WAIT; exits = 0; end
          end
        end
      endcase
    end
    beeping = (ph == P_ALARM) || (ph == P_WAIT);
    if (r && beeping && (prev == P_ALARM || prev == P_WAIT)) age = age + 1;
    else age = 0;
    x.flip    = (ph == P_CLEAR);
    x.inhibit = (ph != P_IDLE);
    x.door    = (ph == P_WAIT) || (ph == P_CLEAR) || (ph == P_SETTLE);
    x.led     = beeping;
`ifdef OVERLOAD_BUZZER_EN
    x.buzz    = beeping && (((age / BH) % 2) == 1);
`else
    x.buzz    = 1'b0;
`endif
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  exp_t got, want;

  // Monitor: one registered output set per edge, compared against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = '{reset_weight_flip, motion_inhibit, door_hold, overload_led, buzzer};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL outputs vec %0d t=%0t got=%b want=%b (flip,inhibit,door,led,buzz)",
                   vectors, $time, got, want);
        end
      end
    end
  end

  initial begin
    logic r, f, m, e;
    // Reset held with the flag high, then release into ALARM.
    repeat (3) apply(0, 1, 1, 0);
    // ALARM while moving long enough for the buzzer to toggle; early pulse ignored.
    repeat (6) apply(1, 1, 1, 0);
    apply(1, 1, 1, 1);
    repeat (6) apply(1, 1, 1, 0);
    apply(1, 1, 0, 0);
    // Two exit pulses three cycles apart, flag drop in between is ignored.
    apply(1, 0, 0, 1);
    repeat (2) apply(1, 1, 0, 0);
    apply(1, 1, 0, 1);
    // CLEAR, then flag low on first SETTLE cycle returns to IDLE.
    repeat (3) apply(1, 0, 0, 0);
    // Re-overload: flag stays high through SETTLE and lands back in WAIT_EXIT.
    repeat (2) apply(1, 1, 0, 0);
    repeat (2) apply(1, 1, 0, 1);
    repeat (20) apply(1, 1, 0, 0);
    // Reach CLEAR again and reset on that edge.
    repeat (2) apply(1, 1, 0, 1);
    apply(0, 1, 0, 0);
    repeat (2) apply(1, 0, 0, 0);

    // Randomized traffic, biased to walk through every phase.
    for (int i = 0; i < 3000; i++) begin
      r = !((ph == P_CLEAR) && ($urandom_range(3) == 0)) && ($urandom_range(299) != 0);
      case (ph)
        P_IDLE:   f = ($urandom_range(2) != 0);
        P_SETTLE: f = ($urandom_range(1) == 0);
        default:  f = $urandom_range(1) == 1;
      endcase
      m = (ph == P_ALARM) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
      e = ($urandom_range(2) == 0);
      apply(r, f, m, e);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
